// File: rtl/host_axi_pkg.sv
// -----------------------------------------------------------------------------
// host_axi_pkg
// Shared definitions for the host memory AXI responder:
//   - fixed 512-bit data path, 64-byte beats
//   - AXI response codes used by the responder (OKAY / SLVERR)
//   - write and read channel FSM state encodings
//   - helper that flags a WLAST that disagrees with the internal beat count
// -----------------------------------------------------------------------------
package host_axi_pkg;

  localparam int DATA_W     = 512;
  localparam int BEAT_BYTES = 64;
  localparam int STRB_W     = BEAT_BYTES;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  // True when the master's WLAST does not match "this is the final counted beat".
  function automatic logic wlast_mismatch(input logic wlast, input logic [7:0] beats_left);
    return wlast ^ (beats_left == 8'd0);
  endfunction

endpackage

// File: rtl/host_mem_ram.sv
// -----------------------------------------------------------------------------
// host_mem_ram
// Simple dual-port RAM of 2^AW words x 512 bits.
// Ports:
//   clk    - clock, rising edge
//   wen    - write enable; bytes with wstrb=1 are written at waddr
//   waddr  - write word index
//   wdata  - write data (512 bits)
//   wstrb  - byte enables (64 bits)
//   ren    - read enable; rdata is loaded from raddr on the next edge
//   raddr  - read word index
//   rdata  - registered read data, holds its value while ren is low
// Contents are not reset. A read and write of the same word in one cycle
// returns the old contents.
// -----------------------------------------------------------------------------
module host_mem_ram
  import host_axi_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic              ren,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];

  // Byte-enabled write port.
  always_ff @(posedge clk) begin
    if (wen) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Registered read port; output only changes on an enabled read.
  always_ff @(posedge clk) begin
    if (ren) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/host_mem_axi_responder.sv
// -----------------------------------------------------------------------------
// host_mem_axi_responder
// AXI4 slave fronting an on-chip 512-bit wide memory. All bursts are INCR with
// 64-byte beats. Write and read channels are independent FSMs sharing one RAM.
// Parameters:
//   C_S_AXI_ID_WIDTH   - AXI ID width
//   C_S_AXI_ADDR_WIDTH - byte address width
//   MEM_AW             - log2 of memory depth in 512-bit words
// Ports:
//   clk, srst                      - clock and synchronous active-high reset
//   s_axi_aw*                      - write address channel (id, addr, len)
//   s_axi_w*                       - write data channel (data, strb, last)
//   s_axi_b*                       - write response channel
//   s_axi_ar*                      - read address channel (id, addr, len)
//   s_axi_r*                       - read data channel
// Word index is addr[MEM_AW+5:6] and wraps within a burst. A write whose WLAST
// disagrees with AWLEN on any beat is still written but answered with SLVERR.
// Reads take two cycles per beat (fetch, then present).
// -----------------------------------------------------------------------------
module host_mem_axi_responder
  import host_axi_pkg::*;
#(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int MEM_AW             = 12
) (
  input  logic                          clk,
  input  logic                          srst,
  // write address
  input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  // write data
  input  logic [DATA_W-1:0]             s_axi_wdata,
  input  logic [STRB_W-1:0]             s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  // write response
  output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  // read address
  input  logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  // read data
  output logic [C_S_AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_W-1:0]             s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_t                    w_state_r;
  logic [C_S_AXI_ID_WIDTH-1:0] bid_r;
  logic [MEM_AW-1:0]           w_idx_r;
  logic [7:0]                  w_cnt_r;    // beats remaining after the current one
  logic                        w_err_r;    // sticky WLAST disagreement
  logic                        awready_r;
  logic                        wready_r;
  logic                        bvalid_r;
  logic [1:0]                  bresp_r;

  logic w_hs_s;
  logic w_mis_s;

  assign w_hs_s  = s_axi_wvalid & wready_r;
  assign w_mis_s = wlast_mismatch(s_axi_wlast, w_cnt_r);

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_t                    r_state_r;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_r;
  logic [MEM_AW-1:0]           r_idx_r;
  logic [7:0]                  r_cnt_r;    // beats remaining after the current one
  logic                        arready_r;
  logic                        rvalid_r;
  logic                        rlast_r;

  logic              ram_ren_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign ram_ren_s = (r_state_r == R_FETCH);

  // Address bits outside the word index carry no meaning for this memory.
  logic addr_unused_s;
  assign addr_unused_s = ^{s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:MEM_AW+6], s_axi_awaddr[5:0],
                           s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:MEM_AW+6], s_axi_araddr[5:0]};

  // Write channel FSM: accept AW, count W beats into the RAM, hold B until taken.
  always_ff @(posedge clk) begin
    if (srst) begin
      w_state_r <= W_IDLE;
      bid_r     <= '0;
      w_idx_r   <= '0;
      w_cnt_r   <= 8'd0;
      w_err_r   <= 1'b0;
      // Idle-ready flag is pre-armed; the port itself is gated by srst below.
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (s_axi_awvalid && awready_r) begin
            bid_r     <= s_axi_awid;
            w_idx_r   <= s_axi_awaddr[MEM_AW+5:6];
            w_cnt_r   <= s_axi_awlen;
            w_err_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            if (w_cnt_r == 8'd0) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= (w_err_r | w_mis_s) ? RESP_SLVERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end else begin
              w_idx_r <= w_idx_r + MEM_AW'(1);
              w_cnt_r <= w_cnt_r - 8'd1;
              w_err_r <= w_err_r | w_mis_s;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b1;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
          bresp_r   <= RESP_OKAY;
        end
      endcase
    end
  end

  // Read channel FSM: accept AR, fetch one word, present it until RREADY.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state_r <= R_IDLE;
      rid_r     <= '0;
      r_idx_r   <= '0;
      r_cnt_r   <= 8'd0;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (s_axi_arvalid && arready_r) begin
            rid_r     <= s_axi_arid;
            r_idx_r   <= s_axi_araddr[MEM_AW+5:6];
            r_cnt_r   <= s_axi_arlen;
            arready_r <= 1'b0;
            r_state_r <= R_FETCH;
          end
        end
        R_FETCH: begin
          // RAM output register is loaded on this edge.
          rvalid_r  <= 1'b1;
          rlast_r   <= (r_cnt_r == 8'd0);
          r_state_r <= R_DATA;
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            if (r_cnt_r == 8'd0) begin
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              r_idx_r   <= r_idx_r + MEM_AW'(1);
              r_cnt_r   <= r_cnt_r - 8'd1;
              r_state_r <= R_FETCH;
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  host_mem_ram #(
    .AW(MEM_AW)
  ) u_ram (
    .clk  (clk),
    .wen  (w_hs_s),
    .waddr(w_idx_r),
    .wdata(s_axi_wdata),
    .wstrb(s_axi_wstrb),
    .ren  (ram_ren_s),
    .raddr(r_idx_r),
    .rdata(ram_rdata_s)
  );

  // Address readies must read low during reset yet be high the first cycle after.
  assign s_axi_awready = awready_r & ~srst;
  assign s_axi_arready = arready_r & ~srst;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bid     = bid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rid     = rid_r;
  assign s_axi_rlast   = rlast_r;
  assign s_axi_rdata   = ram_rdata_s;
  assign s_axi_rresp   = RESP_OKAY;

endmodule
